// File: rtl/cordic_share_arb.sv
// Round-robin arbiter sharing one sequential CORDIC sin/cos engine.
// One trig per accepted job; result or watchdog error returned tagged by id.
module cordic_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int LAT_MAX = 24
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [NUM_REQ-1:0]    req_vld,
  output logic [NUM_REQ-1:0]    req_rdy,
  input  logic [NUM_REQ*10-1:0] req_data,
  output logic                  eng_trig,
  output logic [9:0]            eng_data,
  input  logic                  eng_vld,
  input  logic [12:0]           eng_sin,
  input  logic [12:0]           eng_cos,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [ID_W-1:0]       rsp_id,
  output logic [12:0]           rsp_sin,
  output logic [12:0]           rsp_cos,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int WD_W = $clog2(LAT_MAX + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [9:0]      phase_q, phase_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            trig_q, trig_d;
  logic [9:0]      edata_q, edata_d;
  logic            rvld_q, rvld_d;
  logic [12:0]     rsin_q, rsin_d;
  logic [12:0]     rcos_q, rcos_d;
  logic            rerr_q, rerr_d;

  logic            found;
  logic [ID_W-1:0] gnt;
  logic [9:0]      gnt_phase;
  int              idx;

  // Search starts just after the last grant so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!found && req_vld[idx]) begin
        found = 1'b1;
        gnt   = ID_W'(idx);
      end
    end
  end

  assign gnt_phase = req_data[int'(gnt)*10 +: 10];

  always_comb begin
    req_rdy = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_rdy[i] = sys_rst_n && (state_q == S_IDLE) && found
                   && (gnt == ID_W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    phase_d = phase_q;
    wd_d    = wd_q;
    trig_d  = 1'b0;
    edata_d = edata_q;
    rvld_d  = rvld_q;
    rsin_d  = rsin_q;
    rcos_d  = rcos_q;
    rerr_d  = rerr_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          phase_d = gnt_phase;
          id_d    = gnt;
          last_d  = gnt;
          trig_d  = 1'b1;
          edata_d = gnt_phase;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + WD_W'(1);
        // A result arriving on the timeout cycle still counts as success.
        if (eng_vld) begin
          rsin_d  = eng_sin;
          rcos_d  = eng_cos;
          rerr_d  = 1'b0;
          rvld_d  = 1'b1;
          edata_d = '0;
          state_d = S_RESP;
        end else if (wd_q == WD_W'(LAT_MAX - 1)) begin
          rsin_d  = '0;
          rcos_d  = '0;
          rerr_d  = 1'b1;
          rvld_d  = 1'b1;
          edata_d = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_rdy) begin
          rvld_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      last_q  <= ID_W'(NUM_REQ - 1);
      id_q    <= '0;
      phase_q <= '0;
      wd_q    <= '0;
      trig_q  <= 1'b0;
      edata_q <= '0;
      rvld_q  <= 1'b0;
      rsin_q  <= '0;
      rcos_q  <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      phase_q <= phase_d;
      wd_q    <= wd_d;
      trig_q  <= trig_d;
      edata_q <= edata_d;
      rvld_q  <= rvld_d;
      rsin_q  <= rsin_d;
      rcos_q  <= rcos_d;
      rerr_q  <= rerr_d;
    end
  end

  assign eng_trig = trig_q;
  assign eng_data = edata_q;
  assign rsp_vld  = rvld_q;
  assign rsp_id   = id_q;
  assign rsp_sin  = rsin_q;
  assign rsp_cos  = rcos_q;
  assign rsp_err  = rerr_q;
  assign busy     = (state_q != S_IDLE);

endmodule
